// File: rtl/sync_down_counter.sv
// Loadable down-counter with IDLE/RUN/DONE control FSM and registered tc/busy/done.
// Define SYNC_DOWN_COUNTER_AUTORELOAD_EN to reload q from rv at terminal count instead of stopping.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt, rv, rv_nxt;
  logic             tc_nxt;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    rv_nxt    = rv;
    tc_nxt    = 1'b0;

    // Load overrides start and en in every state, including an abort from RUN.
    if (load) begin
      q_nxt     = load_val;
      rv_nxt    = load_val;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && (q != ZERO)) state_nxt = RUN;
        end
        RUN: begin
          if (en) begin
            if (q > ONE) begin
              q_nxt = q - ONE;
            end else if (q == ONE) begin
              tc_nxt = 1'b1;
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
              if (rv != ZERO) begin
                q_nxt = rv;
              end else begin
                q_nxt     = ZERO;
                state_nxt = DONE;
              end
`else
              q_nxt     = ZERO;
              state_nxt = DONE;
`endif
            end else begin
              // q==0 in RUN is unreachable; retire quietly rather than wrap.
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          if (start && (rv != ZERO)) begin
            q_nxt     = rv;
            state_nxt = RUN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      rv    <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      rv    <= rv_nxt;
      tc    <= tc_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed, table-driven bench for sync_down_counter (WIDTH=4), one-shot or auto-reload build.
module tb_sync_down_counter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            name;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             en;
    logic [WIDTH-1:0] exp_q;
    logic             exp_tc;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  vec_t vecs[$];

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .en       (en),
    .q        (q),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [WIDTH-1:0] eq, input logic etc,
                           input logic eb, input logic ed);
    check({name, ".q"},    16'(q),    16'(eq));
    check({name, ".tc"},   16'(tc),   16'(etc));
    check({name, ".busy"}, 16'(busy), 16'(eb));
    check({name, ".done"}, 16'(done), 16'(ed));
  endtask

  task automatic drive(input logic l, input logic [WIDTH-1:0] lv, input logic s, input logic e);
    @(negedge clk);
    load     = l;
    load_val = lv;
    start    = s;
    en       = e;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic l, input logic [3:0] lv, input logic s,
                     input logic e, input logic [3:0] eq, input logic etc, input logic eb,
                     input logic ed);
    vecs.push_back('{n, l, lv, s, e, eq, etc, eb, ed});
  endtask

  initial begin
    // name, load, load_val, start, en, exp q, tc, busy, done
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
    add("ar_load3",  1, 3, 0, 0, 3, 0, 0, 0);
    add("ar_start",  0, 0, 1, 0, 3, 0, 1, 0);
    add("ar_en1",    0, 0, 0, 1, 2, 0, 1, 0);
    add("ar_en2",    0, 0, 0, 1, 1, 0, 1, 0);
    add("ar_en3",    0, 0, 0, 1, 3, 1, 1, 0);
    add("ar_en4",    0, 0, 0, 1, 2, 0, 1, 0);
    add("ar_en5",    0, 0, 0, 1, 1, 0, 1, 0);
    add("ar_en6",    0, 0, 0, 1, 3, 1, 1, 0);
    add("ar_en7",    0, 0, 0, 1, 2, 0, 1, 0);
    add("ar_en8",    0, 0, 0, 1, 1, 0, 1, 0);
    add("ar_en9",    0, 0, 0, 1, 3, 1, 1, 0);
    add("ar_hold",   0, 0, 0, 0, 3, 0, 1, 0);
    add("ar_abort",  1, 6, 1, 1, 6, 0, 0, 0);
`else
    add("load5",     1, 5, 0, 0, 5, 0, 0, 0);
    add("start",     0, 0, 1, 0, 5, 0, 1, 0);
    add("cnt4",      0, 0, 0, 1, 4, 0, 1, 0);
    add("cnt3",      0, 0, 0, 1, 3, 0, 1, 0);
    add("cnt2",      0, 0, 0, 1, 2, 0, 1, 0);
    add("cnt1",      0, 0, 0, 1, 1, 0, 1, 0);
    add("cnt0_tc",   0, 0, 0, 1, 0, 1, 0, 1);
    add("done_hold", 0, 0, 0, 1, 0, 0, 0, 1);
    add("restart",   0, 0, 1, 0, 5, 0, 1, 0);
    add("rcnt4",     0, 0, 0, 1, 4, 0, 1, 0);
    add("rcnt3",     0, 0, 0, 1, 3, 0, 1, 0);
    add("en0_a",     0, 0, 0, 0, 3, 0, 1, 0);
    add("en0_b",     0, 0, 0, 0, 3, 0, 1, 0);
    add("en0_c",     0, 0, 0, 0, 3, 0, 1, 0);
    add("resume2",   0, 0, 0, 1, 2, 0, 1, 0);
    add("resume1",   0, 0, 0, 1, 1, 0, 1, 0);
    add("resume0",   0, 0, 0, 1, 0, 1, 0, 1);
    add("done_load", 1, 6, 1, 0, 6, 0, 0, 0);
    add("start6",    0, 0, 1, 0, 6, 0, 1, 0);
    add("cnt5",      0, 0, 0, 1, 5, 0, 1, 0);
    add("cnt4b",     0, 0, 0, 1, 4, 0, 1, 0);
    add("load_reload", 1, 6, 0, 0, 6, 0, 0, 0);
    add("start6b",   0, 0, 1, 0, 6, 0, 1, 0);
    add("abort9",    1, 9, 1, 1, 9, 0, 0, 0);
    add("idle_hold", 0, 0, 0, 1, 9, 0, 0, 0);
`endif
    add("load0_win", 1, 0, 1, 0, 0, 0, 0, 0);
    add("start_q0",  0, 0, 1, 1, 0, 0, 0, 0);
    add("start_q0b", 0, 0, 1, 0, 0, 0, 0, 0);
  end

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    load_val = '0;
    start    = 1'b0;
    en       = 1'b0;
    #3;
    check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    // First edge after reset release: start with q==0 must be ignored from IDLE.
    start = 1'b1;
    step();
    check_all("post_reset", 4'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, vecs[i].load_val, vecs[i].start, vecs[i].en);
      step();
      check_all(vecs[i].name, vecs[i].exp_q, vecs[i].exp_tc, vecs[i].exp_busy, vecs[i].exp_done);
    end

    // Asynchronous reset mid-RUN at q=4, observed before the next rising edge.
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    step();
    check_all("pre_arst", 4'd4, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_all("arst_async", 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_all("arst_held", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b1);
    rst = 1'b0;
    step();
    check_all("arst_release", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
